// File: rtl/cpu_power_supervisor.sv
// rtl/cpu_power_supervisor.sv - CPU power-up, heartbeat watchdog and retry/fault supervisor
//
// Owns the CPU sequencer enable. Waits for stable board power-good, enables the
// CPU, then watches a software-toggled heartbeat. A boot or watchdog timeout
// power-cycles the CPU up to MAX_RETRIES times before latching a fault.
//
// Ports:
//   sysclk        in   system clock
//   reset_INV     in   asynchronous active-low reset
//   board_pgood   in   board rail power-good (async, synchronised here)
//   cpu_heartbeat in   CPU heartbeat GPIO, any edge counts (async, synchronised here)
//   shutdown_req  in   level request to power the CPU down (async, synchronised here)
//   cpu_enable    out  sequencer enable, registered
//   fault         out  high in FAULT, registered
//   retry_count   out  consecutive timeout restarts, registered
//   state_dbg     out  current state encoding
module cpu_power_supervisor #(
    parameter int unsigned TICK_DIV    = 5000,
    parameter int unsigned PGOOD_TICKS = 10,
    parameter int unsigned BOOT_TICKS  = 30000,
    parameter int unsigned WDT_TICKS   = 2000,
    parameter int unsigned OFF_TICKS   = 50,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       board_pgood,
    input  logic       cpu_heartbeat,
    input  logic       shutdown_req,
    output logic       cpu_enable,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_POWER_ON    = 3'd1,
        ST_RUNNING     = 3'd2,
        ST_RESTART_OFF = 3'd3,
        ST_SHUTDOWN    = 3'd4,
        ST_FAULT       = 3'd5
    } state_t;

    localparam logic [12:0] TICK_LAST = 13'(TICK_DIV - 1);
    localparam logic [15:0] PGOOD_T   = 16'(PGOOD_TICKS);
    localparam logic [15:0] BOOT_T    = 16'(BOOT_TICKS);
    localparam logic [15:0] WDT_T     = 16'(WDT_TICKS);
    localparam logic [15:0] OFF_T     = 16'(OFF_TICKS);
    localparam logic [2:0]  MAX_R     = 3'(MAX_RETRIES);

    // Two-stage synchronisers; hb_prev_q is the edge-detect history stage.
    logic pg_meta_q, pg_sync_q;
    logic hb_meta_q, hb_sync_q, hb_prev_q;
    logic sd_meta_q, sd_sync_q;

    logic [12:0] presc_q, presc_d;
    logic [15:0] timer_q, timer_d;
    state_t      state_q, state_d;
    logic [2:0]  retry_q, retry_d;
    logic        cpu_enable_q, cpu_enable_d;
    logic        fault_q, fault_d;

    logic tick;
    logic hb_edge;
    logic timeout;

    always_comb begin
        tick    = (presc_q == TICK_LAST);
        hb_edge = hb_sync_q ^ hb_prev_q;
        presc_d = tick ? 13'd0 : presc_q + 13'd1;

        state_d = state_q;
        retry_d = retry_q;
        timeout = 1'b0;

        // FAULT is terminal; everywhere else shutdown beats pgood loss,
        // which beats heartbeat handling, which beats timeouts.
        if (state_q != ST_FAULT) begin
            if (sd_sync_q) begin
                state_d = ST_SHUTDOWN;
            end else if (!pg_sync_q &&
                         (state_q == ST_POWER_ON || state_q == ST_RUNNING)) begin
                state_d = ST_RESTART_OFF;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pg_sync_q && timer_q >= PGOOD_T) begin
                            state_d = ST_POWER_ON;
                        end
                    end
                    ST_POWER_ON: begin
                        if (hb_edge) begin
                            state_d = ST_RUNNING;
                        end else if (timer_q >= BOOT_T) begin
                            timeout = 1'b1;
                        end
                    end
                    ST_RUNNING: begin
                        // A heartbeat edge coincident with expiry counts as alive.
                        if (!hb_edge && timer_q >= WDT_T) begin
                            timeout = 1'b1;
                        end
                    end
                    ST_RESTART_OFF: begin
                        if (timer_q >= OFF_T) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_SHUTDOWN: begin
                        if (timer_q >= OFF_T) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        if (timeout) begin
            if (retry_q == MAX_R) begin
                state_d = ST_FAULT;
            end else begin
                retry_d = retry_q + 3'd1;
                state_d = ST_RESTART_OFF;
            end
        end

        // A deliberate shutdown starts a fresh retry budget.
        if (state_d == ST_SHUTDOWN && state_q != ST_SHUTDOWN) begin
            retry_d = 3'd0;
        end

        if (state_d != state_q ||
            (state_q == ST_RUNNING && hb_edge) ||
            (state_q == ST_IDLE && !pg_sync_q)) begin
            timer_d = 16'd0;
        end else if (tick && timer_q != 16'hFFFF) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end

        // Outputs decode the next state so they change on the same edge as state_q.
        cpu_enable_d = (state_d == ST_POWER_ON) || (state_d == ST_RUNNING);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            pg_meta_q    <= 1'b0;
            pg_sync_q    <= 1'b0;
            hb_meta_q    <= 1'b0;
            hb_sync_q    <= 1'b0;
            hb_prev_q    <= 1'b0;
            sd_meta_q    <= 1'b0;
            sd_sync_q    <= 1'b0;
            presc_q      <= 13'd0;
            timer_q      <= 16'd0;
            state_q      <= ST_IDLE;
            retry_q      <= 3'd0;
            cpu_enable_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pg_meta_q    <= board_pgood;
            pg_sync_q    <= pg_meta_q;
            hb_meta_q    <= cpu_heartbeat;
            hb_sync_q    <= hb_meta_q;
            hb_prev_q    <= hb_sync_q;
            sd_meta_q    <= shutdown_req;
            sd_sync_q    <= sd_meta_q;
            presc_q      <= presc_d;
            timer_q      <= timer_d;
            state_q      <= state_d;
            retry_q      <= retry_d;
            cpu_enable_q <= cpu_enable_d;
            fault_q      <= fault_d;
        end
    end

    assign cpu_enable  = cpu_enable_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_power_supervisor.sv
// tb/tb_cpu_power_supervisor.sv - self-checking bench for cpu_power_supervisor
module tb_cpu_power_supervisor;

    localparam int TD = 4;
    localparam int PG = 3;
    localparam int BT = 20;
    localparam int WD = 10;
    localparam int OF = 5;
    localparam int MR = 2;

    localparam int S_IDLE = 0;
    localparam int S_PON  = 1;
    localparam int S_RUN  = 2;
    localparam int S_ROFF = 3;
    localparam int S_SHUT = 4;
    localparam int S_FLT  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pg_pin;
    logic       hb_pin;
    logic       sd_pin;
    logic       en;
    logic       flt;
    logic [2:0] rc;
    logic [2:0] sdbg;

    always #5 clk = ~clk;

    cpu_power_supervisor #(
        .TICK_DIV   (TD),
        .PGOOD_TICKS(PG),
        .BOOT_TICKS (BT),
        .WDT_TICKS  (WD),
        .OFF_TICKS  (OF),
        .MAX_RETRIES(MR)
    ) dut (
        .sysclk       (clk),
        .reset_INV    (rst_n),
        .board_pgood  (pg_pin),
        .cpu_heartbeat(hb_pin),
        .shutdown_req (sd_pin),
        .cpu_enable   (en),
        .fault        (flt),
        .retry_count  (rc),
        .state_dbg    (sdbg)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: phase state, ticks elapsed in phase, retries, and
    // delay lines of pin samples (index 0 = previous edge).
    int   m_state;
    int   m_ticks;
    int   m_retry;
    int   edge_n;
    logic pg_h [3];
    logic hb_h [3];
    logic sd_h [3];

    typedef struct {
        logic pg;
        logic sd;
        logic tog;
        int   cycles;
        int   st;
        logic en;
        int   rc;
        logic f;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_ticks = 0;
        m_retry = 0;
        edge_n  = 0;
        for (int i = 0; i < 3; i++) begin
            pg_h[i] = 1'b0;
            hb_h[i] = 1'b0;
            sd_h[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic pg_now, input logic hb_now, input logic sd_now);
        logic pg, sd, hbe, tick, tout;
        int   nxt;
        pg   = pg_h[1];
        sd   = sd_h[1];
        hbe  = (hb_h[1] != hb_h[2]);
        tick = ((edge_n % TD) == TD - 1);
        nxt  = m_state;
        tout = 1'b0;
        if (m_state != S_FLT) begin
            if (sd) nxt = S_SHUT;
            else if (!pg && (m_state == S_PON || m_state == S_RUN)) nxt = S_ROFF;
            else if (m_state == S_IDLE) begin
                if (pg && m_ticks >= PG) nxt = S_PON;
            end else if (m_state == S_PON) begin
                if (hbe) nxt = S_RUN;
                else if (m_ticks >= BT) tout = 1'b1;
            end else if (m_state == S_RUN) begin
                if (!hbe && m_ticks >= WD) tout = 1'b1;
            end else if (m_state == S_ROFF || m_state == S_SHUT) begin
                if (m_ticks >= OF) nxt = S_IDLE;
            end
        end
        if (tout) begin
            if (m_retry == MR) nxt = S_FLT;
            else begin
                m_retry = m_retry + 1;
                nxt     = S_ROFF;
            end
        end
        if (nxt == S_SHUT && m_state != S_SHUT) m_retry = 0;
        if (nxt != m_state || (m_state == S_RUN && hbe) || (m_state == S_IDLE && !pg))
            m_ticks = 0;
        else if (tick && m_ticks < 65535)
            m_ticks = m_ticks + 1;
        m_state = nxt;
        pg_h[2] = pg_h[1]; pg_h[1] = pg_h[0]; pg_h[0] = pg_now;
        hb_h[2] = hb_h[1]; hb_h[1] = hb_h[0]; hb_h[0] = hb_now;
        sd_h[2] = sd_h[1]; sd_h[1] = sd_h[0]; sd_h[0] = sd_now;
        edge_n++;
    endtask

    // One clock: capture pins, advance model on the edge, compare 1 ns later.
    task automatic step();
        logic p, h, s;
        int   e_en, e_f;
        p = pg_pin; h = hb_pin; s = sd_pin;
        @(posedge clk);
        model_edge(p, h, s);
        #1;
        e_en = (m_state == S_PON || m_state == S_RUN) ? 1 : 0;
        e_f  = (m_state == S_FLT) ? 1 : 0;
        tests++;
        if (int'(sdbg) != m_state || int'(rc) != m_retry || int'(en) != e_en || int'(flt) != e_f) begin
            fails++;
            $display("FAIL model edge %0d: got state=%0d retry=%0d en=%0d fault=%0d, expected state=%0d retry=%0d en=%0d fault=%0d",
                     edge_n - 1, sdbg, rc, en, flt, m_state, m_retry, e_en, e_f);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int k, m1, xe, mode;

        tbl[0]  = '{1'b1, 1'b0, 1'b0,  20, 1, 1'b1, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1,  20, 2, 1'b1, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1,  20, 2, 1'b1, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1,  30, 2, 1'b1, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0,  20, 3, 1'b0, 1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0,  16, 0, 1'b0, 1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0,  20, 1, 1'b1, 1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1,  20, 2, 1'b1, 1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0,   4, 3, 1'b0, 1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0,  12, 3, 1'b0, 1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0,  12, 0, 1'b0, 1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0,  20, 1, 1'b1, 1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0,  72, 3, 1'b0, 2, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 200, 5, 1'b0, 2, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b1,  50, 5, 1'b0, 2, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1,  20, 5, 1'b0, 2, 1'b1};

        rst_n  = 1'b0;
        pg_pin = 1'b1;
        hb_pin = 1'b0;
        sd_pin = 1'b0;
        #2;
        apply_reset();
        check("reset_state", sdbg, 0);
        check("reset_en", en, 0);
        check("reset_retry", rc, 0);
        check("reset_fault", flt, 0);

        // Directed scenario: boot, watchdog restart, pgood loss, fault latch.
        for (int i = 0; i < 16; i++) begin
            pg_pin = tbl[i].pg;
            sd_pin = tbl[i].sd;
            if (tbl[i].tog) hb_pin = ~hb_pin;
            repeat (tbl[i].cycles) step();
            check($sformatf("tbl%0d_state", i), sdbg, tbl[i].st);
            check($sformatf("tbl%0d_en", i), en, tbl[i].en);
            check($sformatf("tbl%0d_retry", i), rc, tbl[i].rc);
            check($sformatf("tbl%0d_fault", i), flt, tbl[i].f);
        end

        // Fault clears only through reset.
        pg_pin = 1'b1;
        sd_pin = 1'b0;
        apply_reset();
        check("fault_cleared_state", sdbg, 0);
        check("fault_cleared_fault", flt, 0);
        check("fault_cleared_retry", rc, 0);

        // Shutdown synchronised onto the exact watchdog expiry edge.
        for (int i = 0; i < 100 && m_state != S_PON; i++) step();
        check("sd_reach_pon", sdbg, S_PON);
        hb_pin = ~hb_pin;
        k  = edge_n;
        m1 = k + 3;
        while ((m1 % TD) != TD - 1) m1++;
        xe = m1 + (WD - 1) * TD + 1;
        while (edge_n < xe - 2) step();
        sd_pin = 1'b1;
        step();
        step();
        check("sd_before_expiry", sdbg, S_RUN);
        step();
        check("sd_prio_state", sdbg, S_SHUT);
        check("sd_prio_retry", rc, 0);
        check("sd_prio_en", en, 0);
        repeat (8) step();
        check("sd_hold", sdbg, S_SHUT);
        sd_pin = 1'b0;
        for (int i = 0; i < 60 && sdbg != 3'd0; i++) step();
        check("sd_release_idle", sdbg, S_IDLE);

        // Reset asserted between clock edges while in POWER_ON with a nonzero retry.
        for (int i = 0; i < 400 && !(m_state == S_PON && m_retry == 1); i++) step();
        check("mid_pon_retry", rc, 1);
        check("mid_pon_en", en, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_en", en, 0);
        check("async_rst_state", sdbg, 0);
        check("async_rst_retry", rc, 0);
        check("async_rst_fault", flt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Randomised pins against the reference model.
        mode = 0;
        for (int i = 0; i < 4000 && fails < 40; i++) begin
            if (i % 150 == 0) mode = int'($urandom_range(0, 2));
            if (pg_pin) begin
                if ($urandom_range(0, 299) == 0) pg_pin = 1'b0;
            end else if ($urandom_range(0, 5) == 0) pg_pin = 1'b1;
            if (sd_pin) begin
                if ($urandom_range(0, 24) == 0) sd_pin = 1'b0;
            end else if ($urandom_range(0, 499) == 0) sd_pin = 1'b1;
            if (mode == 0 && $urandom_range(0, 15) == 0) hb_pin = ~hb_pin;
            if (mode == 1 && $urandom_range(0, 35) == 0) hb_pin = ~hb_pin;
            if (m_state == S_FLT && $urandom_range(0, 19) == 0) apply_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
